// File: rtl/ustc_sparse_encoder.sv
// Sparse-A lane producer: compacts the nonzeros of dense rows into N_UNIT-lane beats
// and hands each closed beat to the USTC array over a valid/ready handshake.
module ustc_sparse_encoder #(
  parameter int unsigned N_UNIT  = 32,
  parameter int unsigned N_COL   = 8,
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_IDX  = 4,
  parameter int unsigned DW_ROW  = 4,
  parameter int unsigned DW_CTRL = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_COL*DW_DATA-1:0]      in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_UNIT*DW_DATA-1:0]     out_a,
  output logic [N_UNIT*DW_IDX-1:0]      out_a_col,
  output logic [N_UNIT*DW_ROW-1:0]      out_a_row,
  output logic [N_UNIT*DW_CTRL-1:0]     out_a_ctrl,
  output logic [$clog2(N_UNIT+1)-1:0]   out_count
);

  localparam int unsigned CW = $clog2(N_UNIT + 1);

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t                          r_state;
  logic                            r_out_valid;
  logic [CW-1:0]                   r_fill;
  logic [DW_ROW-1:0]               r_row;
  logic [N_UNIT-1:0][DW_DATA-1:0]  r_a;
  logic [N_UNIT-1:0][DW_IDX-1:0]   r_col;
  logic [N_UNIT-1:0][DW_ROW-1:0]   r_lrow;
  logic [N_UNIT-1:0][DW_CTRL-1:0]  r_ctrl;

  logic [N_UNIT-1:0]               w_wr;
  logic [N_UNIT-1:0][DW_DATA-1:0]  w_a;
  logic [N_UNIT-1:0][DW_IDX-1:0]   w_col;
  logic [N_UNIT-1:0][DW_CTRL-1:0]  w_ctrl;
  logic [CW-1:0]                   w_new_fill;
  logic                            w_fits;
  logic                            w_full;

  // Place the incoming row's nonzeros at lanes [fill, fill+k), already shifted into beat position
  always_comb begin : pack_row
    int pos;
    int last;
    w_wr   = '0;
    w_a    = '0;
    w_col  = '0;
    w_ctrl = '0;
    pos    = int'(r_fill);
    for (int c = 0; c < int'(N_COL); c++) begin
      if (in_data[c*DW_DATA +: DW_DATA] != '0) begin
        for (int u = 0; u < int'(N_UNIT); u++) begin
          if (u == pos) begin
            w_wr[u]  = 1'b1;
            w_a[u]   = in_data[c*DW_DATA +: DW_DATA];
            w_col[u] = DW_IDX'(c);
          end
        end
        pos = pos + 1;
      end
    end
    // An all-zero row still occupies one lane (value 0, col 0) so the row is visible downstream
    if (pos == int'(r_fill)) begin
      for (int u = 0; u < int'(N_UNIT); u++) begin
        if (u == pos) w_wr[u] = 1'b1;
      end
      pos = pos + 1;
    end
    last = pos - 1;
    for (int u = 0; u < int'(N_UNIT); u++) begin
      if (w_wr[u]) begin
        w_ctrl[u][0] = 1'b1;
        w_ctrl[u][1] = (u == int'(r_fill));
        w_ctrl[u][2] = (u == last);
      end
    end
    w_fits     = (pos <= int'(N_UNIT));
    w_full     = (pos == int'(N_UNIT));
    w_new_fill = CW'(pos);
  end

  assign in_ready = !reset && (r_state == S_FILL) && w_fits;

  // Fill/emit sequencer; a row that does not fit closes the current beat and waits
  always_ff @(posedge clk or posedge reset) begin : fsm
    if (reset) begin
      r_state     <= S_FILL;
      r_out_valid <= 1'b0;
      r_fill      <= '0;
      r_row       <= '0;
      r_a         <= '0;
      r_col       <= '0;
      r_lrow      <= '0;
      r_ctrl      <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            if (w_fits) begin
              for (int u = 0; u < int'(N_UNIT); u++) begin
                if (w_wr[u]) begin
                  r_a[u]    <= w_a[u];
                  r_col[u]  <= w_col[u];
                  r_lrow[u] <= r_row;
                  r_ctrl[u] <= w_ctrl[u];
                end
              end
              r_fill <= w_new_fill;
              r_row  <= in_last ? '0 : r_row + DW_ROW'(1);
              if (in_last || w_full) begin
                r_state     <= S_EMIT;
                r_out_valid <= 1'b1;
              end
            end else begin
              r_state     <= S_EMIT;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_state     <= S_FILL;
            r_out_valid <= 1'b0;
            r_fill      <= '0;
            r_a         <= '0;
            r_col       <= '0;
            r_lrow      <= '0;
            r_ctrl      <= '0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_a      = r_a;
  assign out_a_col  = r_col;
  assign out_a_row  = r_lrow;
  assign out_a_ctrl = r_ctrl;
  assign out_count  = r_fill;

endmodule
